// File: rtl/int_seq_if.sv
// int_seq_if: interrupt request, CP0 status and pipeline handshake bundle
// between the SoC/CPU side (master) and the int_sequencer (slave).
interface int_seq_if #(
   parameter int NUM_IRQ = 6
);

   logic [NUM_IRQ-1:0] irq_in;
   logic [NUM_IRQ-1:0] irq_mask;
   logic               int_en;
   logic               exl;
   logic [NUM_IRQ-1:0] irq_clr;
   logic               pipe_drained;
   logic               stall_req;
   logic [NUM_IRQ-1:0] cp0_int;
   logic [NUM_IRQ-1:0] pend;
   logic [2:0]         active_id;
   logic               busy;
   logic               err;

   modport master (
      output irq_in,
      output irq_mask,
      output int_en,
      output exl,
      output irq_clr,
      output pipe_drained,
      input  stall_req,
      input  cp0_int,
      input  pend,
      input  active_id,
      input  busy,
      input  err
   );

   modport slave (
      input  irq_in,
      input  irq_mask,
      input  int_en,
      input  exl,
      input  irq_clr,
      input  pipe_drained,
      output stall_req,
      output cp0_int,
      output pend,
      output active_id,
      output busy,
      output err
   );

endinterface

// File: rtl/int_sequencer.sv
// int_sequencer: sync, latch, mask and prioritise interrupts, then run the
// stall/drain/fire/EXL handshake. Macro INT_SEQ_LEVEL_EN selects level pend.
module int_sequencer #(
   parameter int NUM_IRQ     = 6,
   parameter int SYNC_STAGES = 2,
   parameter int EXL_TIMEOUT = 15
) (
   input  logic     clk,
   input  logic     rst,
   int_seq_if.slave bus
);

   localparam int CNT_W = $clog2(EXL_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXL_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_STALL,
      S_FIRE,
      S_WAIT_EXL,
      S_SERVICE
   } state_t;

   state_t             r_state;
   state_t             w_state_nx;

   logic [NUM_IRQ-1:0] r_sync [SYNC_STAGES];
   logic [NUM_IRQ-1:0] w_synced;
   logic [NUM_IRQ-1:0] w_pend;
   logic [NUM_IRQ-1:0] w_elig;
   logic [NUM_IRQ-1:0] w_sel;
   logic [2:0]         w_enc;

   logic               r_stall;
   logic [NUM_IRQ-1:0] r_cp0_int;
   logic [2:0]         r_active_id;
   logic               r_err;
   logic [CNT_W-1:0]   r_cnt;

   logic               w_stall_nx;
   logic [NUM_IRQ-1:0] w_cp0_nx;
   logic [2:0]         w_id_nx;
   logic               w_err_nx;
   logic [CNT_W-1:0]   w_cnt_nx;

   // Multi-flop synchronizer for each raw interrupt line
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            r_sync[s] <= '0;
         end
      end else begin
         r_sync[0] <= bus.irq_in;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            r_sync[s] <= r_sync[s-1];
         end
      end
   end

   assign w_synced = r_sync[SYNC_STAGES-1];

`ifdef INT_SEQ_LEVEL_EN
   logic [NUM_IRQ-1:0] w_unused_clr;

   assign w_unused_clr = bus.irq_clr;
   assign w_pend       = w_synced;
`else
   logic [NUM_IRQ-1:0] r_hist;
   logic [NUM_IRQ-1:0] r_pend;
   logic [NUM_IRQ-1:0] w_rise;

   assign w_rise = w_synced & ~r_hist;

   // Rising-edge latch; a new edge beats a same-cycle clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hist <= '0;
         r_pend <= '0;
      end else begin
         r_hist <= w_synced;
         r_pend <= (r_pend & ~bus.irq_clr) | w_rise;
      end
   end

   assign w_pend = r_pend;
`endif

   assign w_elig = w_pend & bus.irq_mask & {NUM_IRQ{bus.int_en}};

   // Highest set eligible bit wins; later iterations override lower ones
   always_comb begin
      w_sel = '0;
      w_enc = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (w_elig[i]) begin
            w_sel = '0;
            w_sel[i] = 1'b1;
            w_enc = 3'(i);
         end
      end
   end

   // Next-state and next-output logic of the entry sequencer
   always_comb begin
      w_state_nx = r_state;
      w_stall_nx = r_stall;
      w_cp0_nx   = '0;
      w_id_nx    = r_active_id;
      w_err_nx   = r_err;
      w_cnt_nx   = r_cnt;
      unique case (r_state)
         S_IDLE: begin
            w_stall_nx = 1'b0;
            if ((|w_elig) && !bus.exl) begin
               w_state_nx = S_STALL;
               w_stall_nx = 1'b1;
            end
         end
         S_STALL: begin
            w_stall_nx = 1'b1;
            if (!(|w_elig)) begin
               w_state_nx = S_IDLE;
               w_stall_nx = 1'b0;
            end else if (bus.pipe_drained) begin
               w_state_nx = S_FIRE;
               w_cp0_nx   = w_sel;
               w_id_nx    = w_enc;
            end
         end
         S_FIRE: begin
            w_stall_nx = 1'b1;
            w_cnt_nx   = '0;
            w_state_nx = S_WAIT_EXL;
         end
         S_WAIT_EXL: begin
            w_stall_nx = 1'b1;
            if (bus.exl) begin
               w_state_nx = S_SERVICE;
               w_stall_nx = 1'b0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nx = S_IDLE;
               w_stall_nx = 1'b0;
               w_err_nx   = 1'b1;
            end else begin
               w_cnt_nx = r_cnt + 1'b1;
            end
         end
         S_SERVICE: begin
            w_stall_nx = 1'b0;
            if (!bus.exl) begin
               w_state_nx = S_IDLE;
            end
         end
         default: begin
            w_state_nx = S_IDLE;
            w_stall_nx = 1'b0;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_stall     <= 1'b0;
         r_cp0_int   <= '0;
         r_active_id <= '0;
         r_err       <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_state     <= w_state_nx;
         r_stall     <= w_stall_nx;
         r_cp0_int   <= w_cp0_nx;
         r_active_id <= w_id_nx;
         r_err       <= w_err_nx;
         r_cnt       <= w_cnt_nx;
      end
   end

   assign bus.stall_req = r_stall;
   assign bus.cp0_int   = r_cp0_int;
   assign bus.pend      = w_pend;
   assign bus.active_id = r_active_id;
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.err       = r_err;

endmodule
